mem_access_unit: RTL and testbench

- Load/store front-end between the datapath and the word-addressed data RAM (combinational read, write on posedge).
- Accepts byte-addressed requests of byte/half/word size.
- Word-aligned requests go straight through; sub-word loads are extracted with sign/zero extension.
- Sub-word stores use a two-cycle read-modify-write.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 16 +
 rtl/mem_access_unit.sv | 113 +++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and byte-lane helpers shared by mem_access_unit.
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    // Bit offset of the addressed lane; words are always aligned so they never shift.
    function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo, input logic [1:0] size);
        return size == SZ_HALF ? {addr_lo[1], 4'b0000} : size == SZ_BYTE ? {addr_lo, 3'b000} : 5'd0;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] addr_lo,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = word >> lane_shift(addr_lo, size);
        return size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
               size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] addr_lo, input logic [1:0] size);
        logic [31:0] m;
        logic [4:0] sh;
        sh = lane_shift(addr_lo, size);
        m = size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (old & ~(m << sh)) | ((wdata & m) << sh);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane extract (loads) and merge (sub-word RMW stores).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] old,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    assign ext    = lane_extract(word, addr_lo, size, sgn);
    assign merged = lane_merge(old, wdata, addr_lo, size);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front-end to a word RAM with sub-word RMW stores.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ACCESS_STATS_EN
   ,output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errors
`endif
);
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    state_t state, state_d;
    logic [31:0] addr_q;
    logic [1:0] size_q;
    logic write_q, signed_q, err_q;
    logic [DATA_W-1:0] wdata_q, data_q, ext, merged;
    logic req_err, sub_store;

    assign req_err = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00) || req_addr[31:2] >= DEPTH_IDX;
    assign sub_store = write_q && size_q != SZ_WORD;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = req_valid ? (req_err ? RESP : ACCESS) : IDLE;
            ACCESS:  state_d = sub_store ? MERGE : RESP;
            MERGE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // data_q holds the extracted load lane, or the old word for a sub-word store.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_err;
                wdata_q  <= req_wdata;
            end
            if (state == ACCESS) data_q <= sub_store ? mem_rdata : ext;
        end

    mem_lane_align u_align (
        .word    (mem_rdata),
        .old     (data_q),
        .wdata   (wdata_q),
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .sgn     (signed_q),
        .ext     (ext),
        .merged  (merged)
    );

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? data_q : '0;
    assign rsp_error = rsp_valid && err_q;
    assign mem_read  = state == ACCESS && (!write_q || sub_store);
    assign mem_write = (state == ACCESS && write_q && !sub_store) || state == MERGE;
    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign mem_wdata = state == MERGE ? merged : (state == ACCESS && write_q) ? wdata_q : '0;

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (state == RESP) begin
            if (err_q) stat_errors <= stat_errors + 16'(stat_errors != 16'hFFFF);
            else if (write_q) stat_stores <= stat_stores + 16'(stat_stores != 16'hFFFF);
            else stat_loads <= stat_loads + 16'(stat_loads != 16'hFFFF);
        end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench against a byte-array reference memory.
module tb_mem_access_unit;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, rsp_valid, rsp_error, mem_read, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    mem_access_unit #(.DEPTH_WORDS(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
       ,.stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] ram [32];
    assign mem_rdata = ram[mem_addr[4:0]];
    always @(posedge clk)
        if (clr) for (int i = 0; i < 32; i++) ram[i] <= '0;
        else if (mem_write) ram[mem_addr[4:0]] <= mem_wdata;

    typedef struct {logic [31:0] rdata; logic err; int acc; int lat;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] rq[$];
    logic [63:0] wq[$];
    logic [63:0] mon_w;
    logic [31:0] mon_r;
    logic [7:0] ref_mem [128];
    int checks = 0, errors = 0, cyc = 0, mem_act = 0, rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a >= 128;
    endfunction

    function automatic logic [31:0] ref_word(input int i);
        return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a+k]) << (8*k));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++) ref_mem[a+k] = 8'(wd >> (8*k));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst) begin
            if (mem_read || mem_write) mem_act++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_error", rsp_error, mon_e.err);
                    chk("latency", cyc - mon_e.acc, mon_e.lat);
                    chk("ready_in_resp", req_ready, 0);
                end
            end
            if (mem_write) begin
                if (wq.size() == 0) fail_now("unexpected_write");
                else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", mem_addr, mon_w[63:32]);
                    chk("wr_data", mem_wdata, mon_w[31:0]);
                end
            end
            if (mem_read) begin
                if (rq.size() == 0) fail_now("unexpected_read");
                else begin
                    mon_r = rq.pop_front();
                    chk("rd_addr", mem_addr, mon_r);
                end
            end
        end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("ready_timeout");
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        e.err = model_err(a, sz);
        e.rdata = '0;
        if (!e.err) begin
            if (w) begin
                ref_store(a, sz, wd);
                wq.push_back({a >> 2, ref_word(int'(a >> 2))});
                if (sz != 2'd2) rq.push_back(a >> 2);
            end else begin
                e.rdata = ref_load(a, sz, sg);
                rq.push_back(a >> 2);
            end
        end
        e.acc = cyc;
        e.lat = e.err ? 1 : (w && sz != 2'd2) ? 3 : 2;
        exp_q.push_back(e);
        if (!hold) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int act0, r0;
        logic w;
        logic [1:0] sz;
        logic [31:0] a;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        clr = 1'b0;
        rst = 1'b1;

        issue(1, 2'd2, 0, 32'h10, 32'h1234_5678, 0);
        issue(0, 2'd0, 1, 32'h13, 32'h0, 0);
        issue(1, 2'd0, 0, 32'h11, 32'h0000_00AB, 0);
        issue(0, 2'd0, 1, 32'h11, 32'h0, 0);
        issue(0, 2'd0, 0, 32'h11, 32'h0, 0);
        issue(1, 2'd1, 0, 32'h12, 32'h0000_BEEF, 0);
        issue(0, 2'd1, 1, 32'h12, 32'h0, 0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        drain();

        act0 = mem_act;
        issue(0, 2'd1, 0, 32'h01, 32'h0, 0);
        issue(0, 2'd2, 0, 32'h06, 32'h0, 0);
        issue(0, 2'd2, 0, 32'h80, 32'h0, 0);
        issue(1, 2'd3, 0, 32'h04, 32'hDEAD_BEEF, 0);
        issue(1, 2'd2, 0, 32'h8000_0000, 32'hDEAD_BEEF, 0);
        drain();
        chk("err_no_mem_access", mem_act, act0);

        // Abort a byte store in its merge cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h10; req_wdata = 32'hFF;
        rq.push_back(32'd4);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("merge_write_high", mem_write, 1);
        rst = 1'b0;
        #1 chk("abort_mem_write", mem_write, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_ram_kept", ram[4], ref_word(4));
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        drain();

        r0 = rsp_cnt;
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
        issue(0, 2'd2, 0, 32'h00, 32'h0, 1);
        issue(0, 2'd2, 0, 32'h14, 32'h0, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        chk("b2b_rsp_count", rsp_cnt - r0, 3);

        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 1);
            issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
        end
        drain();
        repeat (3) @(negedge clk);
        if (wq.size() != 0 || rq.size() != 0) fail_now("mem_queue_leftover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
